// File: rtl/rtc_timer_mux.sv
// Virtual-timer scheduler: keeps the RTC mtimecmp loaded with the earliest armed
// deadline among NUM_TIMERS slots and raises a pending bit per expired slot.
module rtc_timer_mux #(
   parameter int NUM_TIMERS = 4,
   parameter int IDX_W      = $clog2(NUM_TIMERS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_arm_i,
   input  logic [IDX_W-1:0]      req_idx_i,
   input  logic [63:0]           req_deadline_i,
   input  logic [NUM_TIMERS-1:0] clr_i,
   output logic [NUM_TIMERS-1:0] pending_o,
   output logic                  irq_o,
   output logic                  rtc_en_o,
   output logic [3:0]            rtc_addr_o,
   output logic [7:0]            rtc_we_o,
   output logic [63:0]           rtc_data_o,
   input  logic                  rtc_mti_i,
   input  logic [63:0]           rtc_mtime_i
);

   typedef enum logic [2:0] {
      ST_SCAN   = 3'd0,
      ST_PROG   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_IDLE   = 3'd3,
      ST_EXPIRE = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [63:0]             min_q, min_d;
   logic [63:0]             snap_q, snap_d;
   logic [63:0]             deadline_q [NUM_TIMERS];
   logic [63:0]             deadline_d [NUM_TIMERS];
   logic [NUM_TIMERS-1:0]   armed_q, armed_d;
   logic [NUM_TIMERS-1:0]   pending_q, pending_d;
   logic [NUM_TIMERS-1:0]   set_s;
   logic [63:0]             base_s;
   logic                    last_s;

   assign last_s = (idx_q == IDX_W'(NUM_TIMERS - 1));

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SCAN;
         idx_q      <= '0;
         min_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
         snap_q     <= 64'h0;
         deadline_q <= '{default: 64'h0};
         armed_q    <= '0;
         pending_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         min_q      <= min_d;
         snap_q     <= snap_d;
         deadline_q <= deadline_d;
         armed_q    <= armed_d;
         pending_q  <= pending_d;
      end
   end

   // Next-state: slot walk for SCAN/EXPIRE, request/mti arbitration in IDLE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      min_d      = min_q;
      snap_d     = snap_q;
      deadline_d = deadline_q;
      armed_d    = armed_q;
      set_s      = '0;
      base_s     = (idx_q == '0) ? 64'hFFFF_FFFF_FFFF_FFFF : min_q;

      case (state_q)
         ST_SCAN: begin
            if (armed_q[idx_q] && (deadline_q[idx_q] < base_s)) begin
               min_d = deadline_q[idx_q];
            end else begin
               min_d = base_s;
            end
            if (last_s) begin
               state_d = ST_PROG;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_PROG: begin
            state_d = ST_SETTLE;
            idx_d   = '0;
         end
         ST_SETTLE: begin
            // Two cycles so the RTC's registered mti reflects the new compare value.
            if (idx_q == IDX_W'(1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_IDLE: begin
            if (req_valid_i) begin
               if (req_arm_i) begin
                  deadline_d[req_idx_i] = req_deadline_i;
                  armed_d[req_idx_i]    = 1'b1;
               end else begin
                  armed_d[req_idx_i]    = 1'b0;
               end
               state_d = ST_SCAN;
               idx_d   = '0;
            end else if (rtc_mti_i) begin
               snap_d  = rtc_mtime_i;
               state_d = ST_EXPIRE;
               idx_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXPIRE: begin
            if (armed_q[idx_q] && (deadline_q[idx_q] <= snap_q)) begin
               set_s[idx_q]   = 1'b1;
               armed_d[idx_q] = 1'b0;
            end else begin
               set_s = '0;
            end
            if (last_s) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_SCAN;
            idx_d   = '0;
         end
      endcase

      // An expiry set beats a simultaneous clear on the same slot.
      pending_d = (pending_q & ~clr_i) | set_s;
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rtc_en_o    = (state_q == ST_PROG);
   assign rtc_addr_o  = rtc_en_o ? 4'h8 : 4'h0;
   assign rtc_we_o    = rtc_en_o ? 8'hFF : 8'h00;
   assign rtc_data_o  = rtc_en_o ? min_q : 64'h0;
   assign pending_o   = pending_q;
   assign irq_o       = |pending_q;

endmodule

// File: doc/rtc_timer_mux.md
# rtc_timer_mux

Virtual-timer scheduler in front of the `rtc` block. It holds `NUM_TIMERS` independent 64-bit deadlines and keeps the RTC's single `mtimecmp` programmed with the earliest armed deadline. It drives the RTC's write port itself. When the RTC's `mti_o` fires, it identifies every expired slot and raises a per-slot pending bit toward the interrupt controller.

## Interface
- `NUM_TIMERS`, default 4: number of virtual timer slots, range 2..16.
- `IDX_W`, default `$clog2(NUM_TIMERS)`: width of the slot index.
- Clocking: one clock, `clk`. Reset is asynchronous and active-low, `reset_n`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  host request valid.
- `req_ready_o`  out  1  request accepted when valid && ready.
- `req_arm_i`  in  1  1 = arm slot, 0 = disarm slot.
- `req_idx_i`  in  IDX_W  target slot.
- `req_deadline_i`  in  64  absolute mtime deadline, used for arm only.
- `clr_i`  in  NUM_TIMERS  per-slot pending clear, one-cycle pulse.
- `pending_o`  out  NUM_TIMERS  per-slot expired flags.
- `irq_o`  out  1  OR of `pending_o`.
- `rtc_en_o`  out  1  RTC access enable.
- `rtc_addr_o`  out  4  RTC address.
- `rtc_we_o`  out  8  RTC byte write enables.
- `rtc_data_o`  out  64  RTC write data.
- `rtc_mti_i`  in  1  RTC `mti_o`.
- `rtc_mtime_i`  in  64  RTC `mtime_o`.

## Operation
- Per-slot state: `deadline[i]` (64 bits) and `armed[i]`. Reset value of both is 0.
- FSM states: SCAN, PROG, SETTLE, IDLE, EXPIRE. The reset state is SCAN.
- **IDLE**
  - `req_ready_o` = 1 in IDLE only.
  - An accepted arm writes `deadline[idx]` and sets `armed[idx]`.
  - An accepted disarm clears `armed[idx]`. A disarm never touches `pending`.
  - Next state after an accepted request: SCAN.
  - Otherwise, if `rtc_mti_i` = 1: latch `snap <= rtc_mtime_i` and go to EXPIRE.
  - A request has priority over `rtc_mti_i` in the same cycle. The mti is serviced after reprogramming because it remains asserted.
- **EXPIRE**
  - One slot per cycle, i = 0..N-1.
  - If `armed[i]` && `deadline[i] <= snap` (unsigned): set `pending[i]`, clear `armed[i]`.
  - After slot N-1, go to SCAN.
- **SCAN**
  - One slot per cycle, i = 0..N-1.
  - `min` starts at 64'hFFFF_FFFF_FFFF_FFFF. `min <= deadline[i]` if `armed[i]` && `deadline[i] < min`.
  - After slot N-1, go to PROG.
  - With no slot armed, `min` stays all-ones.
- **PROG**
  - Exactly one cycle of `rtc_en_o` = 1, `rtc_addr_o` = 4'h8, `rtc_we_o` = 8'hFF, `rtc_data_o` = `min`. This is a full 64-bit `mtimecmp` write.
  - Next state: SETTLE.
- **SETTLE**: two cycles, covering the RTC's registered `mti_o` latency. Then go to IDLE.
- **Pending bits**
  - `clr_i[i]` clears `pending[i]`.
  - A set from EXPIRE wins over `clr_i` on the same slot in the same cycle.
  - `irq_o` = `|pending_o`.
- **Boundary conditions**
  - A deadline already in the past when armed is programmed. `mti` then rises and the slot expires on the next EXPIRE pass.
  - Equal deadlines in several slots expire in the same pass.
  - `rtc_mti_i` high with no expired slot (stale) is allowed. The pass ends with a reprogram and no pending bits are set.
  - A re-arm of an armed slot overwrites its deadline.
  - Reset mid-operation: all state returns to reset values. The FSM restarts in SCAN and reprograms `mtimecmp` to all-ones. This overrides the RTC's reset `mtimecmp` = 0, which would otherwise fire immediately.
  - Behaviour at an mtime wrap past 2^64-1 is unspecified.
- The RTC is never read. `rtc_en_o` is asserted in PROG only.

## Timing
- Reset values: `req_ready_o` = 0, `pending_o` = 0, `irq_o` = 0, `rtc_en_o` = 0, `rtc_addr_o` = 0, `rtc_we_o` = 0, `rtc_data_o` = 0.
- All outputs are registered or decoded from state registers only. There is no combinational input-to-output path.
- Request accepted in cycle A:
  - SCAN runs in cycles A+1..A+N.
  - The write cycle is W = A+N+1.
  - SETTLE occupies W+1..W+2.
  - `req_ready_o` is high again at A+N+4.
- After reset deasserts:
  - The first write occurs in cycle N.
  - `req_ready_o` first goes high in cycle N+3.
- `rtc_mti_i` sampled high in IDLE cycle T:
  - EXPIRE runs in T+1..T+N.
  - `pending[i]` is visible the cycle after slot i is checked, at T+2+i.
  - Ready returns at T+2N+4.
- After the write in cycle W, `rtc_mti_i` is not sampled before W+3.

## Test plan
- Reset, then hold. Expect exactly one RTC write of all-ones in cycle N (cycle 4 for N = 4), then `req_ready_o` = 1, `pending_o` = 0, no further writes.
- Arm slot 2 @ 500 and slot 0 @ 300, with mtime near 0. Expect writes of 500, then 300. At mtime ≈ 301, expect `pending_o` = 4'b0001, then a write of 500. Later expect `pending_o` = 4'b0101 and a final write of all-ones.
- Arm slot 1 @ 10 while mtime = 1000 (past deadline). Expect `pending_o[1]` = 1 within 2N+8 cycles of acceptance and a final write of all-ones.
- Arm slots 0 and 3 both @ 800. Expect both pending bits set in the same EXPIRE pass and `irq_o` = 1. Pulse `clr_i` = 4'b1001 and expect `irq_o` = 0.
- Arm slot 0 @ 400, then disarm it before 400. Expect a write of all-ones and no pending bit. Separately, assert `clr_i[2]` in the cycle EXPIRE sets `pending[2]` and expect `pending[2]` = 1.
- Assert `reset_n` low during SCAN with slots armed. Expect `rtc_en_o` = 0 immediately and all outputs at reset values. After release, expect a write of all-ones and `armed` = 0.
